// File: rtl/sprite_pixel_drawer.sv
// sprite_pixel_drawer: streams an 8x8 sprite or background patch to a VGA adapter, one pixel per cycle
module sprite_pixel_drawer #(
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        drawChar,
  input  logic        drawBG,
  input  logic [7:0]  xIn,
  input  logic [6:0]  yIn,
  output logic [5:0]  romAddr,
  input  logic [2:0]  romData,
  output logic [14:0] bgAddr,
  input  logic [2:0]  bgData,
  output logic [7:0]  vgaX,
  output logic [6:0]  vgaY,
  output logic [2:0]  vgaColour,
  output logic        plot,
  output logic        doneChar,
  output logic        doneBG,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic        r_bg;
  logic        r_valid, r_inb;
  logic [7:0]  r_px;
  logic [6:0]  r_py;
  logic [8:0]  w_px;
  logic [7:0]  w_py;
  logic        w_inb, w_start;
  // Pixel coordinates kept one bit wider than the screen so the clip test never sees a wrapped value
  always_comb begin
    w_start = drawBG | drawChar;
    w_px    = {1'b0, r_x} + {6'b0, r_cnt[2:0]};
    w_py    = {1'b0, r_y} + {5'b0, r_cnt[5:3]};
    w_inb   = (w_px < 9'd240) && (w_py < 8'd120);
    romAddr = r_cnt;
    bgAddr  = w_inb ? ({7'b0, w_py} * 15'd240 + {6'b0, w_px}) : 15'd0;
  end
  // Next-state logic: RUN walks all 64 pixels, FLUSH drains the ROM latency, DONE pulses completion
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE)  ? (w_start ? S_RUN : S_IDLE) :
             (r_state == S_RUN)   ? ((r_cnt == 6'd63) ? S_FLUSH : S_RUN) :
             (r_state == S_FLUSH) ? S_DONE : S_IDLE;
  end
  // Outputs come from the pipe stage, aligned with the one-cycle ROM read
  always_comb begin
    busy      = r_state != S_IDLE;
    doneChar  = (r_state == S_DONE) && !r_bg;
    doneBG    = (r_state == S_DONE) && r_bg;
    vgaX      = r_px;
    vgaY      = r_py;
    vgaColour = r_bg ? bgData : romData;
    plot      = r_valid && r_inb && (r_bg || (romData != TRANSPARENT));
  end
  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end
  // Start latch and pixel counter; BG wins when both requests arrive together
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 6'd0;
      r_x   <= 8'd0;
      r_y   <= 7'd0;
      r_bg  <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_cnt <= 6'd0;
      r_x   <= xIn;
      r_y   <= yIn;
      r_bg  <= drawBG;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 6'd1;
    end
  end
  // Pipe stage carrying the pixel issued last cycle, valid only for RUN issues
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_inb   <= 1'b0;
      r_px    <= 8'd0;
      r_py    <= 7'd0;
    end else begin
      r_valid <= r_state == S_RUN;
      r_inb   <= w_inb;
      r_px    <= w_px[7:0];
      r_py    <= w_py[6:0];
    end
  end
endmodule

// File: tb/tb_sprite_pixel_drawer.sv
// tb_sprite_pixel_drawer: randomized and directed checks of sprite_pixel_drawer against a cycle-indexed model
module tb_sprite_pixel_drawer;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        drawChar = 1'b0, drawBG = 1'b0;
  logic [7:0]  xIn = 8'd0;
  logic [6:0]  yIn = 7'd0;
  logic [5:0]  romAddr;
  logic [2:0]  romData = 3'd0;
  logic [14:0] bgAddr;
  logic [2:0]  bgData = 3'd0;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;
  logic [2:0]  vgaColour;
  logic        plot, doneChar, doneBG, busy;

  sprite_pixel_drawer dut (
    .clock(clock), .resetn(resetn), .drawChar(drawChar), .drawBG(drawBG),
    .xIn(xIn), .yIn(yIn), .romAddr(romAddr), .romData(romData),
    .bgAddr(bgAddr), .bgData(bgData), .vgaX(vgaX), .vgaY(vgaY),
    .vgaColour(vgaColour), .plot(plot), .doneChar(doneChar), .doneBG(doneBG), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [2:0] rom [64];
  int pass_cnt = 0, total = 0;
  int e = 0, s_edge = -1000;
  bit m_active = 0, m_bg = 0;
  int mx = 0, my = 0;
  int nplots, fx, fy, lx, ly, ndc, ndb, dc_n, db_n;

  function automatic logic [2:0] bgpix(int a);
    return 3'((a * 5) ^ (a >> 4));
  endfunction

  // Synchronous ROM models: data one cycle after address
  always @(posedge clock) begin
    romData <= rom[romAddr];
    bgData  <= bgpix(int'(bgAddr));
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s edge %0d: got %0d expected %0d", name, e, act, exp);
  endtask

  task automatic clear_tally();
    nplots = 0; fx = -1; fy = -1; lx = -1; ly = -1; ndc = 0; ndb = 0; dc_n = -1; db_n = -1;
  endtask

  // Model: a run is fully described by its start edge, base and mode; everything else is arithmetic on n
  always @(posedge clock) begin
    int n, k, px, py;
    bit act, inb, ep;
    e++;
    if (!resetn) m_active = 0;
    else if ((!m_active || e > s_edge + 66) && (drawBG || drawChar)) begin
      m_active = 1; s_edge = e; mx = int'(xIn); my = int'(yIn); m_bg = drawBG;
    end
    #1;
    n = e - s_edge + 1;
    act = m_active && resetn && n <= 66;
    chk("busy", int'(busy), int'(act));
    chk("doneChar", int'(doneChar), int'(act && n == 66 && !m_bg));
    chk("doneBG", int'(doneBG), int'(act && n == 66 && m_bg));
    k = n - 2;
    if (act && k >= 0 && k <= 63) begin
      px = mx + k % 8; py = my + k / 8;
      inb = px < 240 && py < 120;
      ep = inb && (m_bg || rom[k] != 3'b000);
      chk("plot", int'(plot), int'(ep));
      chk("vgaX", int'(vgaX), px % 256);
      chk("vgaY", int'(vgaY), py % 128);
      if (ep) chk("colour", int'(vgaColour), int'(m_bg ? bgpix(py * 240 + px) : rom[k]));
    end else chk("plot", int'(plot), 0);
    if (act && n >= 1 && n <= 64) begin
      px = mx + (n - 1) % 8; py = my + (n - 1) / 8;
      chk("romAddr", int'(romAddr), n - 1);
      chk("bgAddr", int'(bgAddr), (px < 240 && py < 120) ? py * 240 + px : 0);
    end
    if (!resetn) begin
      chk("rst_romAddr", int'(romAddr), 0);
      chk("rst_bgAddr", int'(bgAddr), 0);
    end
    if (plot) begin
      nplots++;
      if (fx < 0) begin fx = int'(vgaX); fy = int'(vgaY); end
      lx = int'(vgaX); ly = int'(vgaY);
    end
    if (doneChar) begin ndc++; dc_n = n; end
    if (doneBG) begin ndb++; db_n = n; end
  end

  task automatic start(bit c, bit b, int x, int y);
    @(negedge clock);
    drawChar = c; drawBG = b; xIn = 8'(x); yIn = 7'(y);
    @(negedge clock);
    drawChar = 0; drawBG = 0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int r, g;
    foreach (rom[i]) rom[i] = 3'd0;
    clear_tally();
    idle(3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_plot", int'(plot), 0);
    resetn = 1;
    idle(2);
    // Solid sprite at (10,20)
    foreach (rom[i]) rom[i] = 3'b101;
    clear_tally();
    start(1, 0, 10, 20);
    idle(68);
    chk("solid_plots", nplots, 64);
    chk("solid_first_x", fx, 10);
    chk("solid_first_y", fy, 20);
    chk("solid_last_x", lx, 17);
    chk("solid_last_y", ly, 27);
    chk("solid_done_cycle", dc_n, 66);
    chk("solid_done_count", ndc, 1);
    // Checkerboard with half the pixels transparent
    for (int i = 0; i < 64; i++) rom[i] = ((i % 2) ^ ((i / 8) % 2)) != 0 ? 3'b010 : 3'b000;
    clear_tally();
    start(1, 0, 100, 50);
    idle(68);
    chk("checker_plots", nplots, 32);
    chk("checker_done_cycle", dc_n, 66);
    // Background patch clipped at the bottom-right corner
    clear_tally();
    start(0, 1, 236, 116);
    chk("corner_bgAddr", int'(bgAddr), 28076);
    idle(68);
    chk("corner_plots", nplots, 16);
    chk("corner_doneBG", db_n, 66);
    chk("corner_no_doneChar", ndc, 0);
    // Simultaneous requests take BG; a later drawChar is ignored
    clear_tally();
    start(1, 1, 50, 60);
    idle(20);
    drawChar = 1; xIn = 8'd5; yIn = 7'd5;
    @(negedge clock);
    drawChar = 0;
    idle(47);
    chk("both_doneBG", ndb, 1);
    chk("both_no_doneChar", ndc, 0);
    chk("both_plots", nplots, 64);
    // Reset in the middle of a run
    foreach (rom[i]) rom[i] = 3'b101;
    clear_tally();
    start(1, 0, 30, 40);
    idle(29);
    resetn = 0;
    #1;
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_busy", int'(busy), 0);
    idle(2);
    resetn = 1;
    idle(70);
    chk("midrst_no_doneChar", ndc, 0);
    chk("midrst_no_doneBG", ndb, 0);
    clear_tally();
    start(1, 0, 0, 0);
    idle(68);
    chk("postrst_plots", nplots, 64);
    chk("postrst_done_cycle", dc_n, 66);
    // Random runs, with stray requests sprinkled across the run and DONE
    for (int t = 0; t < 30; t++) begin
      foreach (rom[i]) rom[i] = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      g = $urandom_range(0, 2);
      start(g != 1, g != 0, $urandom_range(0, 255), $urandom_range(0, 127));
      r = $urandom_range(0, 65);
      idle(r);
      drawChar = 1'($urandom_range(0, 1)); drawBG = ~drawChar;
      xIn = 8'($urandom_range(0, 255)); yIn = 7'($urandom_range(0, 127));
      @(negedge clock);
      drawChar = 0; drawBG = 0;
      idle(65 - r + $urandom_range(0, 2));
    end
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
